// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding, forwarding selects and instruction field positions
package hazard_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, FLUSH = 2'd2} state_t;
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: combinational EX operand forwarding select (EX/MEM beats MEM/WB, x0 never forwards)
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REGW = 5
) (
  input  logic [REGW-1:0] rs,
  input  logic            exmem_regwrite,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            memwb_regwrite,
  input  logic [REGW-1:0] memwb_rd,
  output logic [1:0]      sel
);
  always_comb
    sel = (exmem_regwrite && exmem_rd != '0 && exmem_rd == rs) ? FWD_EXMEM :
          (memwb_regwrite && memwb_rd != '0 && memwb_rd == rs) ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall, branch flush, EX forwarding selects and saturating stall counter
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int N        = 32,
  parameter int REGW     = 5,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1,
  parameter int CNTW     = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    instruction,
  input  logic            idex_memread,
  input  logic [REGW-1:0] idex_rd,
  input  logic [REGW-1:0] idex_rs1,
  input  logic [REGW-1:0] idex_rs2,
  input  logic            exmem_regwrite,
  input  logic [REGW-1:0] exmem_rd,
  input  logic            memwb_regwrite,
  input  logic [REGW-1:0] memwb_rd,
  input  logic            branch_taken,
  output logic            pc_write,
  output logic            ifid_write,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [CNTW-1:0] stall_count
);
  state_t          r_state, w_state_next;
  logic [2:0]      r_cnt, w_cnt_next;
  logic [CNTW-1:0] r_stall_count;
  logic [REGW-1:0] w_rs1, w_rs2;
  logic            w_lu_hit;
  logic [1:0]      w_fwd_a, w_fwd_b;
  assign w_rs1    = instruction[RS1_LSB +: REGW];
  assign w_rs2    = instruction[RS2_LSB +: REGW];
  assign w_lu_hit = idex_memread && idex_rd != '0 && (idex_rd == w_rs1 || idex_rd == w_rs2);
  fwd_sel #(.REGW(REGW)) u_fwd_a (
    .rs(idex_rs1), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .sel(w_fwd_a)
  );
  fwd_sel #(.REGW(REGW)) u_fwd_b (
    .rs(idex_rs2), .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .sel(w_fwd_b)
  );
  assign fwd_a       = rst ? FWD_RF : w_fwd_a;
  assign fwd_b       = rst ? FWD_RF : w_fwd_b;
  assign stall_count = r_stall_count;
  // Outputs are forced to their idle values while rst is high so a reset never leaves a bubble.
  always_comb begin
    w_state_next = RUN;
    w_cnt_next   = '0;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    if (!rst) begin
      if (branch_taken) begin
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        w_state_next = (BR_FLUSH == 2) ? FLUSH : RUN;
      end else if (r_state == STALL) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_bubble  = 1'b1;
        w_cnt_next   = r_cnt - 3'd1;
        w_state_next = (r_cnt == 3'd1) ? RUN : STALL;
      end else if (r_state == FLUSH) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (w_lu_hit) begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_bubble  = 1'b1;
        w_state_next = (LOAD_LAT == 1) ? RUN : STALL;
        w_cnt_next   = 3'(LOAD_LAT - 1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_cnt         <= '0;
      r_stall_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (!pc_write && r_stall_count != '1) r_stall_count <= r_stall_count + 1'b1;
    end
  end
endmodule
